// File: rtl/button_event_decoder_pkg.sv
// ---------------------------------------------------------------------------
// button_event_decoder_pkg
//   Shared definitions for the button event decoder: event-code constants,
//   FSM state encodings, timer width and the saturating timer increment.
//   Configuration macro BTN_DOUBLE_CLICK_EN (used by the top level) decides
//   whether the WAIT_SECOND / SECOND_PRESS states are reachable.
// ---------------------------------------------------------------------------
package button_event_decoder_pkg;

  // Event codes presented on evt_code. EVT_NONE is never shown while valid.
  typedef enum logic [1:0] {
    EVT_NONE   = 2'b00,
    EVT_SHORT  = 2'b01,
    EVT_LONG   = 2'b10,
    EVT_DOUBLE = 2'b11
  } evt_code_e;

  // Gesture FSM state encodings.
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESSED      = 3'd1,
    HELD         = 3'd2,
    WAIT_SECOND  = 3'd3,
    SECOND_PRESS = 3'd4
  } btn_state_e;

  localparam int TCNT_W      = 16;  // per-state tick timer width
  localparam int SYNC_STAGES = 2;   // flops in the pb_in synchronizer

  // Tick timer increment that sticks at all-ones instead of wrapping.
  function automatic logic [TCNT_W-1:0] tcnt_inc(input logic [TCNT_W-1:0] v);
    return (v == {TCNT_W{1'b1}}) ? v : v + TCNT_W'(1);
  endfunction

endpackage

// File: rtl/button_event_decoder_tick.sv
// ---------------------------------------------------------------------------
// tick_gen
//   Free-running divider producing a one-cycle tick every TICK_DIV src_clk
//   cycles. It is never restarted by button activity, only by rst.
//   Ports:
//     src_clk - clock, rising edge
//     rst     - synchronous active-high reset (counter to 0)
//     tick    - one-cycle pulse, high while the counter sits at TICK_DIV-1
// ---------------------------------------------------------------------------
module tick_gen #(
  parameter int TICK_DIV = 48000
) (
  input  logic src_clk,
  input  logic rst,
  output logic tick
);

  // Keep at least one bit so TICK_DIV=1 still elaborates (tick every cycle).
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             last;

  assign last     = (cnt_reg == CNT_W'(TICK_DIV - 1));
  assign cnt_next = last ? '0 : cnt_reg + CNT_W'(1);
  assign tick     = last;

  always_ff @(posedge src_clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// ---------------------------------------------------------------------------
// button_event_decoder
//   Classifies presses of a debounced push button into SHORT, LONG and
//   DOUBLE click events and offers them on a valid/ready port with a sticky
//   overflow flag for events dropped while the consumer was stalled.
//
//   Configuration: define BTN_DOUBLE_CLICK_EN to enable double-click
//   detection. Without it a release from PRESSED reports SHORT at once,
//   code 11 is never produced and DBL_TICKS has no effect.
//
//   Parameters:
//     TICK_DIV   - src_clk cycles per timing tick
//     LONG_TICKS - ticks of continuous hold that make a press LONG
//     DBL_TICKS  - ticks after a release in which a second press is DOUBLE
//   Ports:
//     src_clk   - clock, rising edge
//     rst       - synchronous active-high reset
//     pb_in     - debounced button level, 1 = pressed, asynchronous
//     evt_ready - consumer accepts the pending event
//     ovf_clr   - clears ovf
//     evt_valid - an event is pending
//     evt_code  - 01 SHORT, 10 LONG, 11 DOUBLE
//     ovf       - sticky, set when an event was dropped
// ---------------------------------------------------------------------------
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int TICK_DIV   = 48000,
  parameter int LONG_TICKS = 800,
  parameter int DBL_TICKS  = 250
) (
  input  logic       src_clk,
  input  logic       rst,
  input  logic       pb_in,
  input  logic       evt_ready,
  input  logic       ovf_clr,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       ovf
);

  // A timer "reaches" N on the tick edge that would take it from N-1 to N,
  // so the decision lands on the same edge as the Nth tick.
  localparam logic [TCNT_W-1:0] LONG_LIMIT = TCNT_W'(LONG_TICKS - 1);

  logic tick;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .src_clk(src_clk),
    .rst    (rst),
    .tick   (tick)
  );

  // -------------------------------------------------------------------------
  // Synchronizer plus a parallel fill marker that tells when the last stage
  // holds a real sample of pb_in rather than its reset value.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic [SYNC_STAGES-1:0] fill_reg;
  logic [SYNC_STAGES-1:0] fill_next;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = pb_in;
        assign fill_next[gi] = 1'b1;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
        assign fill_next[gi] = fill_reg[gi-1];
      end
    end
  endgenerate

  logic level;        // synchronized button level
  logic level_real;   // level is a genuine sample, not reset fill
  logic prev_reg;     // level one cycle earlier
  logic armed_reg;    // a genuine released level has been seen since reset
  logic press_edge;
  logic rel_edge;

  assign level      = sync_reg[SYNC_STAGES-1];
  assign level_real = fill_reg[SYNC_STAGES-1];

  // A button held through reset must be released before it can press again,
  // so rising edges only count once a real 0 has been observed.
  assign press_edge = armed_reg & level & ~prev_reg;
  assign rel_edge   = ~level & prev_reg;

  always_ff @(posedge src_clk) begin
    if (rst) begin
      sync_reg  <= '0;
      fill_reg  <= '0;
      prev_reg  <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      sync_reg <= sync_next;
      fill_reg <= fill_next;
      prev_reg <= level;
      if (level_real && !level) begin
        armed_reg <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Gesture FSM next-state decode
  // -------------------------------------------------------------------------
  btn_state_e        state_reg;
  btn_state_e        state_next;
  logic [TCNT_W-1:0] tcnt_reg;
  logic [TCNT_W-1:0] tcnt_next;
  logic              emit;
  evt_code_e         emit_code;
  logic              long_hit;

  assign long_hit = tick && (tcnt_reg >= LONG_LIMIT);

`ifdef BTN_DOUBLE_CLICK_EN
  localparam logic [TCNT_W-1:0] DBL_LIMIT = TCNT_W'(DBL_TICKS - 1);
  logic dbl_hit;
  assign dbl_hit = tick && (tcnt_reg >= DBL_LIMIT);
`else
  // DBL_TICKS has no role without double-click detection.
  logic [31:0] unused_dbl_ticks;
  assign unused_dbl_ticks = 32'(DBL_TICKS);
`endif

  always_comb begin
    state_next = state_reg;
    tcnt_next  = tick ? tcnt_inc(tcnt_reg) : tcnt_reg;
    emit       = 1'b0;
    emit_code  = EVT_NONE;

    case (state_reg)
      IDLE: begin
        if (press_edge) begin
          state_next = PRESSED;
        end
      end

      PRESSED: begin
        // A release on the same edge as the LONG limit means the button was
        // no longer pressed, so release takes priority.
        if (rel_edge) begin
`ifdef BTN_DOUBLE_CLICK_EN
          state_next = WAIT_SECOND;
`else
          state_next = IDLE;
          emit       = 1'b1;
          emit_code  = EVT_SHORT;
`endif
        end else if (long_hit) begin
          state_next = HELD;
          emit       = 1'b1;
          emit_code  = EVT_LONG;
        end
      end

      HELD: begin
        if (rel_edge) begin
          state_next = IDLE;
        end
      end

`ifdef BTN_DOUBLE_CLICK_EN
      WAIT_SECOND: begin
        // While we are still here tcnt is below DBL_TICKS, so a press wins
        // even on the edge where the window would otherwise close.
        if (press_edge) begin
          state_next = SECOND_PRESS;
        end else if (dbl_hit) begin
          state_next = IDLE;
          emit       = 1'b1;
          emit_code  = EVT_SHORT;
        end
      end

      SECOND_PRESS: begin
        if (rel_edge) begin
          state_next = IDLE;
          emit       = 1'b1;
          emit_code  = EVT_DOUBLE;
        end
      end
`endif

      default: begin
        state_next = IDLE;
      end
    endcase

    // Every state entry starts its timer from zero.
    if (state_next != state_reg) begin
      tcnt_next = '0;
    end
  end

  // -------------------------------------------------------------------------
  // FSM state and event output register
  // -------------------------------------------------------------------------
  logic      evt_valid_reg;
  evt_code_e evt_code_reg;
  logic      ovf_reg;
  logic      drop;

  // A new event meets an unaccepted one: keep the old, flag the loss.
  assign drop = emit & evt_valid_reg & ~evt_ready;

  always_ff @(posedge src_clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      tcnt_reg      <= '0;
      evt_valid_reg <= 1'b0;
      evt_code_reg  <= EVT_NONE;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      tcnt_reg  <= tcnt_next;

      if (emit && !drop) begin
        evt_valid_reg <= 1'b1;
        evt_code_reg  <= emit_code;
      end else if (!emit && evt_valid_reg && evt_ready) begin
        evt_valid_reg <= 1'b0;
      end

      if (drop) begin
        ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  assign evt_valid = evt_valid_reg;
  assign evt_code  = evt_code_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_button_event_decoder.sv
module tb_button_event_decoder;

  localparam int TICK_DIV   = 4;
  localparam int LONG_TICKS = 8;
  localparam int DBL_TICKS  = 5;

`ifdef BTN_DOUBLE_CLICK_EN
  localparam bit DBL_EN = 1'b1;
`else
  localparam bit DBL_EN = 1'b0;
`endif

  localparam logic [1:0] C_SHORT  = 2'b01;
  localparam logic [1:0] C_LONG   = 2'b10;
  localparam logic [1:0] C_DOUBLE = 2'b11;

  logic       src_clk = 1'b0;
  logic       rst = 1'b1;
  logic       pb_in = 1'b0;
  logic       evt_ready = 1'b1;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       ovf;

  button_event_decoder #(
    .TICK_DIV  (TICK_DIV),
    .LONG_TICKS(LONG_TICKS),
    .DBL_TICKS (DBL_TICKS)
  ) dut (
    .src_clk  (src_clk),
    .rst      (rst),
    .pb_in    (pb_in),
    .evt_ready(evt_ready),
    .ovf_clr  (ovf_clr),
    .evt_valid(evt_valid),
    .evt_code (evt_code),
    .ovf      (ovf)
  );

  always #5 src_clk = ~src_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: gesture described by press count, whether the button
  // is down, whether LONG already fired, and ticks since the last button edge.
  int         n_edges;        // edges since reset released
  bit         hq[$];          // last few pb_in samples, oldest first
  bit         g_active, g_down, g_long, g_second;
  int         g_t;
  bit         m_valid;
  logic [1:0] m_code;
  bit         m_ovf;

  logic [1:0] acc_q[$];       // codes accepted by the consumer
  bit         cur_ready = 1'b1;
  bit         cur_clr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit pb, input bit rdy, input bit clr, input bit r);
    bit press, rel, tk, emit, drop;
    logic [1:0] ec;
    if (r) begin
      n_edges = 0;
      hq.delete();
      g_active = 0; g_down = 0; g_long = 0; g_second = 0; g_t = 0;
      m_valid = 0; m_code = 2'b00; m_ovf = 0;
      return;
    end
    n_edges++;
    hq.push_back(pb);
    if (hq.size() > 4) void'(hq.pop_front());
    // The decision at this edge sees pb_in as sampled two edges earlier,
    // compared with the sample before that; both must be post-reset samples.
    press = (hq.size() == 4) && hq[1] && !hq[0];
    rel   = (hq.size() == 4) && !hq[1] && hq[0];
    tk    = (n_edges % TICK_DIV) == 0;
    emit  = 0;
    ec    = 2'b00;
    if (!g_active) begin
      if (press) begin
        g_active = 1; g_down = 1; g_long = 0; g_second = 0; g_t = 0;
      end
    end else if (g_long) begin
      if (rel) g_active = 0;
    end else if (g_second) begin
      if (rel) begin emit = 1; ec = C_DOUBLE; g_active = 0; end
    end else if (g_down) begin
      if (rel) begin
        if (DBL_EN) begin g_down = 0; g_t = 0; end
        else begin emit = 1; ec = C_SHORT; g_active = 0; end
      end else if (tk) begin
        g_t++;
        if (g_t >= LONG_TICKS) begin emit = 1; ec = C_LONG; g_long = 1; end
      end
    end else begin
      if (press) begin g_second = 1; g_down = 1; end
      else if (tk) begin
        g_t++;
        if (g_t >= DBL_TICKS) begin emit = 1; ec = C_SHORT; g_active = 0; end
      end
    end
    drop = emit && m_valid && !rdy;
    if (emit) begin
      if (!drop) begin m_valid = 1; m_code = ec; end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic step(input bit pb, input bit rdy, input bit clr, input bit r);
    pb_in = pb; evt_ready = rdy; ovf_clr = clr; rst = r;
    if (!r && evt_valid === 1'b1 && rdy) acc_q.push_back(evt_code);
    @(posedge src_clk);
    model_edge(pb, rdy, clr, r);
    #1;
    check("evt_valid", 32'(evt_valid), 32'(m_valid));
    check("evt_code", 32'(evt_code), 32'(m_code));
    check("ovf", 32'(ovf), 32'(m_ovf));
    $display("t=%0t pb=%0b rdy=%0b clr=%0b rst=%0b -> valid=%0b code=%0b ovf=%0b",
             $time, pb, rdy, clr, r, evt_valid, evt_code, ovf);
  endtask

  task automatic hold(input bit pb, input int cycles);
    for (int i = 0; i < cycles; i++) step(pb, cur_ready, cur_clr, 1'b0);
  endtask

  initial begin
    bit rpb;
    int run;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_code", 32'(evt_code), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    hold(0, 10);

    // Short press
    acc_q.delete();
    hold(1, 12); hold(0, 40);
    check("short_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("short_code", 32'(acc_q[0]), 32'(C_SHORT));

    // Long press, no event on release
    acc_q.delete();
    hold(1, 40); hold(0, 20);
    check("long_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("long_code", 32'(acc_q[0]), 32'(C_LONG));

    // Double click (two SHORTs without the double-click feature)
    acc_q.delete();
    hold(1, 8); hold(0, 8); hold(1, 8); hold(0, 40);
    if (DBL_EN) begin
      check("dbl_count", 32'(acc_q.size()), 32'd1);
      if (acc_q.size() > 0) check("dbl_code", 32'(acc_q[0]), 32'(C_DOUBLE));
    end else begin
      check("dbl_count", 32'(acc_q.size()), 32'd2);
      if (acc_q.size() > 1) begin
        check("dbl_code0", 32'(acc_q[0]), 32'(C_SHORT));
        check("dbl_code1", 32'(acc_q[1]), 32'(C_SHORT));
      end
    end

    // Stalled consumer: second event dropped, ovf set, then cleared
    cur_ready = 0;
    hold(1, 8); hold(0, 40); hold(1, 8); hold(0, 40);
    check("stall_valid", 32'(evt_valid), 32'd1);
    check("stall_code", 32'(evt_code), 32'(C_SHORT));
    check("stall_ovf", 32'(ovf), 32'd1);
    cur_ready = 1;
    hold(0, 1);
    check("ack_valid", 32'(evt_valid), 32'd0);
    check("ack_ovf_kept", 32'(ovf), 32'd1);
    cur_clr = 1; hold(0, 1); cur_clr = 0;
    check("ovf_cleared", 32'(ovf), 32'd0);

    // Reset mid-press with the button still held
    hold(0, 5);
    acc_q.delete();
    hold(1, 6);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    hold(1, 60);
    check("held_no_event", 32'(acc_q.size()), 32'd0);
    check("held_valid", 32'(evt_valid), 32'd0);
    hold(0, 10); hold(1, 8); hold(0, 40);
    check("repress_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("repress_code", 32'(acc_q[0]), 32'(C_SHORT));

    // Randomized traffic against the model
    rpb = 0;
    run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        rpb = ~rpb;
        run = $urandom_range(1, 45);
      end
      run--;
      step(rpb, ($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 500) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 SHALL have parameter TICK_DIV, default 48000, meaning src_clk cycles per timing tick (1 ms at `CLK_REF of 48 MHz).
REQ-002 SHALL have parameter LONG_TICKS, default 800, meaning ticks of continuous hold that classify a press as long.
REQ-003 SHALL have parameter DBL_TICKS, default 250, meaning the window in ticks after a release in which a second press forms a double click.
REQ-004 SHALL have port src_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port pb_in, input, 1 bit: debounced button level from Debounce; 1 means pressed; asynchronous to src_clk.
REQ-007 SHALL have port evt_ready, input, 1 bit: consumer accepts the pending event.
REQ-008 SHALL have port ovf_clr, input, 1 bit: clears ovf.
REQ-009 SHALL have port evt_valid, output, 1 bit: an event is pending.
REQ-010 SHALL have port evt_code, output, 2 bits: 01 = SHORT, 10 = LONG, 11 = DOUBLE; 00 never presented while valid.
REQ-011 SHALL have port ovf, output, 1 bit: sticky flag set when an event was dropped.

Function
REQ-012 SHALL pass pb_in through a 2-flop synchronizer; press and release are edges of the synchronized level, recognized 3 src_clk cycles after pb_in changes.
REQ-013 SHALL generate a one-cycle tick every TICK_DIV src_clk cycles; the tick counter runs freely and is not restarted by button activity.
REQ-014 SHALL implement the FSM states IDLE, PRESSED, HELD, WAIT_SECOND and SECOND_PRESS, with tcnt (16 bits, saturating) cleared on every state entry and incremented on each tick.
REQ-015 IDLE: on press, go to PRESSED.
REQ-016 PRESSED: when tcnt reaches LONG_TICKS while still pressed, emit LONG and go to HELD; on release, go to WAIT_SECOND (or emit SHORT and go to IDLE, see REQ-025).
REQ-017 HELD: on release, go to IDLE with no event.
REQ-018 WAIT_SECOND: on press with tcnt < DBL_TICKS, go to SECOND_PRESS; when tcnt reaches DBL_TICKS, emit SHORT and go to IDLE.
REQ-019 SECOND_PRESS: on release, emit DOUBLE and go to IDLE, regardless of hold duration.
REQ-020 Emission SHALL load evt_code and set evt_valid on the same edge as the emitting transition; evt_code SHALL be held stable while evt_valid=1.
REQ-021 evt_valid SHALL clear on the edge where evt_valid and evt_ready are both 1.
REQ-022 If a new event occurs while evt_valid=1 and evt_ready=0, the new event SHALL be dropped, the old event kept, and ovf set.
REQ-023 If a new event occurs while evt_valid=1 and evt_ready=1, the new event SHALL be loaded and evt_valid stays 1 (no drop).
REQ-024 ovf SHALL clear on ovf_clr=1; if ovf_clr and a drop occur in the same cycle, set wins.

Reset
REQ-025 With rst=1 at a src_clk edge, the block SHALL go to FSM=IDLE, tcnt=0, tick counter=0, synchronizer=00, evt_valid=0, evt_code=00 and ovf=0; a reset mid-gesture discards it with no event.
REQ-026 After reset, a button already held (synchronized level 1) SHALL NOT count as a press; the button must be released and pressed again.

Configuration
REQ-027 Macro BTN_DOUBLE_CLICK_EN defined: full FSM as above.
REQ-028 Macro BTN_DOUBLE_CLICK_EN undefined: WAIT_SECOND and SECOND_PRESS are removed; release in PRESSED emits SHORT immediately; code 11 is never produced; DBL_TICKS is unused.

Structure
REQ-029 Event-code constants (EVT_SHORT, EVT_LONG, EVT_DOUBLE) and the FSM state encodings SHALL live in the shared config include.
REQ-030 SHALL contain one sub-module, tick_gen (parameter TICK_DIV; ports src_clk, rst, tick).

Verification (TICK_DIV=4, LONG_TICKS=8, DBL_TICKS=5, evt_ready=1 unless stated)
REQ-031 Press for 12 src_clk cycles, release, idle for 40 cycles -> exactly one SHORT (01), emitted 5 ticks after release.
REQ-032 Press for 40 cycles -> LONG (10) emitted at the 8th tick of the hold; release -> no further event.
REQ-033 Press 8 cycles, release 8 cycles, press 8 cycles, release -> one DOUBLE (11) on the second release, with no SHORT.
REQ-034 evt_ready=0, two SHORT gestures -> evt_code stays 01, ovf=1; raise evt_ready -> evt_valid clears after one cycle; pulse ovf_clr -> ovf=0.
REQ-035 rst pulsed during PRESSED, button kept held 60 cycles -> no event until a release then a fresh press.
REQ-036 BTN_DOUBLE_CLICK_EN undefined, REQ-033 stimulus -> two SHORT events, each emitted 3 cycles after its release edge.
